// File: rtl/riscv_pkg.sv
// Shared RISC-V datapath definitions: ALU control encoding and the default
// datapath width, used by the ALU-control decoder and the execute stage.
package riscv_pkg;

    localparam int XLEN = 64;

    // Encoding follows the classic 4-bit ALU-control field. Every other code
    // is treated as AND, which is also what the decoder emits by default.
    typedef enum logic [3:0] {
        ALU_AND = 4'b0000,
        ALU_OR  = 4'b0001,
        ALU_ADD = 4'b0010,
        ALU_SUB = 4'b0110
    } ALU_ctrl_t;

endpackage

// File: rtl/alu_core.sv
// Purely combinational ALU: AND / OR / ADD / SUB with a zero flag.
// All arithmetic wraps modulo 2^W.
module alu_core
    import riscv_pkg::*;
#(
    parameter int W = XLEN
) (
    input  logic [W-1:0] i_op_a,
    input  logic [W-1:0] i_op_b,
    input  ALU_ctrl_t    i_alu_ctrl,
    output logic [W-1:0] o_result,
    output logic         o_zero
);

    logic [W-1:0] w_result;

    // Operation select; unknown encodings fall back to AND.
    always_comb begin
        w_result = i_op_a & i_op_b;
        case (i_alu_ctrl)
            ALU_OR:  w_result = i_op_a | i_op_b;
            ALU_ADD: w_result = i_op_a + i_op_b;
            ALU_SUB: w_result = i_op_a - i_op_b;
            default: w_result = i_op_a & i_op_b;
        endcase
    end

    assign o_result = w_result;
    assign o_zero   = (w_result == '0);

endmodule

// File: rtl/alu_exec_stage.sv
// Execute stage: computes the ALU result for each accepted operation and holds
// it in a valid/ready output register for the memory stage.
// Optional activity counters are built when ALU_EXEC_ACTIVITY_CNT_EN is defined.
//
// Handshake: a side transfers when valid && ready are both high at a rising
// edge. in_ready = !out_valid || out_ready, so a full register that is also
// being drained can accept a new operation in the same cycle (no bubble).
// flush wins over everything: the output register empties and any operation
// offered in that cycle is dropped.
module alu_exec_stage
    import riscv_pkg::*;
#(
    parameter int XLEN  = riscv_pkg::XLEN,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  ALU_ctrl_t        in_alu_ctrl,
    input  logic [XLEN-1:0]  in_op_a,
    input  logic [XLEN-1:0]  in_op_b,
    input  logic [TAG_W-1:0] in_rd,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result,
    output logic             out_zero,
    output logic [TAG_W-1:0] out_rd
`ifdef ALU_EXEC_ACTIVITY_CNT_EN
    ,
    output logic [31:0]      cnt_ops,
    output logic [31:0]      cnt_stall,
    output logic [31:0]      cnt_flush
`endif
);

    logic             r_out_valid;
    logic [XLEN-1:0]  r_out_result;
    logic             r_out_zero;
    logic [TAG_W-1:0] r_out_rd;

    // Operand-isolation registers: last accepted operands, held while idle.
    logic [XLEN-1:0]  r_op_a;
    logic [XLEN-1:0]  r_op_b;
    ALU_ctrl_t        r_alu_ctrl;

    logic             w_in_xfer;
    logic             w_out_xfer;
    logic             w_take;
    logic [XLEN-1:0]  w_alu_a;
    logic [XLEN-1:0]  w_alu_b;
    ALU_ctrl_t        w_alu_ctrl;
    logic [XLEN-1:0]  w_alu_result;
    logic             w_alu_zero;

    assign in_ready   = !r_out_valid || out_ready;
    assign w_in_xfer  = in_valid && in_ready;
    assign w_out_xfer = r_out_valid && out_ready;
    // A flushed input counts as accepted but is never loaded.
    assign w_take     = w_in_xfer && !flush;

    // The ALU only sees live decode operands on a real load; otherwise it is
    // fed the held operands so its inputs stay static while idle.
    assign w_alu_a    = w_take ? in_op_a     : r_op_a;
    assign w_alu_b    = w_take ? in_op_b     : r_op_b;
    assign w_alu_ctrl = w_take ? in_alu_ctrl : r_alu_ctrl;

    alu_core #(
        .W (XLEN)
    ) u_alu_core (
        .i_op_a     (w_alu_a),
        .i_op_b     (w_alu_b),
        .i_alu_ctrl (w_alu_ctrl),
        .o_result   (w_alu_result),
        .o_zero     (w_alu_zero)
    );

    // Operand-isolation registers load only on an accepted, non-flushed op.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op_a     <= '0;
            r_op_b     <= '0;
            r_alu_ctrl <= ALU_AND;
        end else if (w_take) begin
            r_op_a     <= in_op_a;
            r_op_b     <= in_op_b;
            r_alu_ctrl <= in_alu_ctrl;
        end
    end

    // Output valid: flush empties, a load fills, a drain without load empties.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
        end else if (flush) begin
            r_out_valid <= 1'b0;
        end else if (w_take) begin
            r_out_valid <= 1'b1;
        end else if (w_out_xfer) begin
            r_out_valid <= 1'b0;
        end
    end

    // Output payload loads on a real load and otherwise holds its last value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_result <= '0;
            r_out_zero   <= 1'b0;
            r_out_rd     <= '0;
        end else if (w_take) begin
            r_out_result <= w_alu_result;
            r_out_zero   <= w_alu_zero;
            r_out_rd     <= in_rd;
        end
    end

    assign out_valid  = r_out_valid;
    assign out_result = r_out_result;
    assign out_zero   = r_out_zero;
    assign out_rd     = r_out_rd;

`ifdef ALU_EXEC_ACTIVITY_CNT_EN
    logic [31:0] r_cnt_ops;
    logic [31:0] r_cnt_stall;
    logic [31:0] r_cnt_flush;

    // Saturating activity counters for power modelling.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt_ops   <= '0;
            r_cnt_stall <= '0;
            r_cnt_flush <= '0;
        end else begin
            if (w_out_xfer && (r_cnt_ops != 32'hFFFF_FFFF)) begin
                r_cnt_ops <= r_cnt_ops + 32'd1;
            end
            if (r_out_valid && !out_ready && (r_cnt_stall != 32'hFFFF_FFFF)) begin
                r_cnt_stall <= r_cnt_stall + 32'd1;
            end
            if (flush && (r_out_valid || w_in_xfer) && (r_cnt_flush != 32'hFFFF_FFFF)) begin
                r_cnt_flush <= r_cnt_flush + 32'd1;
            end
        end
    end

    assign cnt_ops   = r_cnt_ops;
    assign cnt_stall = r_cnt_stall;
    assign cnt_flush = r_cnt_flush;
`endif

endmodule

// File: tb/tb_alu_exec_stage.sv
// Directed testbench for alu_exec_stage: a vector table applied back-to-back,
// plus hand-written stall, flush and reset sequences.
module tb_alu_exec_stage;
    import riscv_pkg::*;

    localparam int W  = 64;
    localparam int TW = 5;
    localparam int NV = 8;

    logic          clk;
    logic          rst_n;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    ALU_ctrl_t     in_alu_ctrl;
    logic [W-1:0]  in_op_a;
    logic [W-1:0]  in_op_b;
    logic [TW-1:0] in_rd;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_result;
    logic          out_zero;
    logic [TW-1:0] out_rd;
`ifdef ALU_EXEC_ACTIVITY_CNT_EN
    logic [31:0]   cnt_ops;
    logic [31:0]   cnt_stall;
    logic [31:0]   cnt_flush;
`endif

    typedef struct {
        ALU_ctrl_t     ctrl;
        logic [W-1:0]  a;
        logic [W-1:0]  b;
        logic [TW-1:0] rd;
        logic [W-1:0]  exp_result;
        logic          exp_zero;
    } vec_t;

    vec_t vec [NV];
    int   n_vec;
    int   n_miss;

    alu_exec_stage #(
        .XLEN  (W),
        .TAG_W (TW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_alu_ctrl (in_alu_ctrl),
        .in_op_a     (in_op_a),
        .in_op_b     (in_op_b),
        .in_rd       (in_rd),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_result  (out_result),
        .out_zero    (out_zero),
        .out_rd      (out_rd)
`ifdef ALU_EXEC_ACTIVITY_CNT_EN
        ,
        .cnt_ops     (cnt_ops),
        .cnt_stall   (cnt_stall),
        .cnt_flush   (cnt_flush)
`endif
    );

    // Clock generation.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Advance one clock and sample just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input ALU_ctrl_t c, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [TW-1:0] rd);
        in_valid    = 1'b1;
        in_alu_ctrl = c;
        in_op_a     = a;
        in_op_b     = b;
        in_rd       = rd;
    endtask

    task automatic chk_out(input string name, input logic v, input logic [W-1:0] r,
                           input logic z, input logic [TW-1:0] rd);
        chk({name, ".valid"},  W'(out_valid), W'(v));
        chk({name, ".result"}, out_result, r);
        chk({name, ".zero"},   W'(out_zero), W'(z));
        chk({name, ".rd"},     W'(out_rd), W'(rd));
    endtask

    initial begin
        n_vec  = 0;
        n_miss = 0;

        vec[0] = '{ALU_ADD, 64'h7, 64'h9, 5'd1, 64'h10, 1'b0};
        vec[1] = '{ALU_SUB, 64'h5, 64'h5, 5'd2, 64'h0, 1'b1};
        vec[2] = '{ALU_ADD, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 5'd3, 64'h0, 1'b1};
        vec[3] = '{ALU_AND, 64'hF0, 64'h3C, 5'd4, 64'h30, 1'b0};
        vec[4] = '{ALU_OR,  64'hF0, 64'h3C, 5'd5, 64'hFC, 1'b0};
        vec[5] = '{ALU_SUB, 64'h0, 64'h1, 5'd6, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
        vec[6] = '{ALU_ctrl_t'(4'hF), 64'hFF00, 64'h0FF0, 5'd7, 64'h0F00, 1'b0};
        vec[7] = '{ALU_ADD, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 5'd8, 64'h0, 1'b1};

        rst_n       = 1'b0;
        flush       = 1'b0;
        in_valid    = 1'b0;
        in_alu_ctrl = ALU_AND;
        in_op_a     = '0;
        in_op_b     = '0;
        in_rd       = '0;
        out_ready   = 1'b1;

        // Reset state.
        repeat (3) step();
        rst_n = 1'b1;
        step();
        chk("reset.in_ready", W'(in_ready), W'(1'b1));
        chk_out("reset", 1'b0, 64'h0, 1'b0, 5'd0);

        // Table vectors, one per cycle, no bubbles expected.
        for (int i = 0; i < NV; i++) begin
            offer(vec[i].ctrl, vec[i].a, vec[i].b, vec[i].rd);
            step();
            chk_out($sformatf("vec%0d", i), 1'b1, vec[i].exp_result, vec[i].exp_zero, vec[i].rd);
        end

        // Drain: valid drops, payload holds.
        in_valid = 1'b0;
        step();
        chk_out("drain", 1'b0, 64'h0, 1'b1, 5'd8);

        // Stall: AND lands, then hold out_ready low for 3 cycles with OR offered.
        offer(ALU_AND, 64'hF0, 64'h3C, 5'd10);
        step();
        chk_out("stall.load", 1'b1, 64'h30, 1'b0, 5'd10);
        offer(ALU_OR, 64'hF0, 64'h3C, 5'd11);
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("stall%0d.in_ready", k), W'(in_ready), W'(1'b0));
            step();
            chk_out($sformatf("stall%0d", k), 1'b1, 64'h30, 1'b0, 5'd10);
        end
        out_ready = 1'b1;
        #1;
        chk("release.in_ready", W'(in_ready), W'(1'b1));
        step();
        chk_out("release", 1'b1, 64'hFC, 1'b0, 5'd11);
        in_valid = 1'b0;
        step();
        chk_out("release.drain", 1'b0, 64'hFC, 1'b0, 5'd11);

        // Flush while full and a new op is offered.
        offer(ALU_ADD, 64'h1, 64'h2, 5'd12);
        step();
        chk_out("flush.load", 1'b1, 64'h3, 1'b0, 5'd12);
        offer(ALU_ADD, 64'h100, 64'h1, 5'd13);
        out_ready = 1'b0;
        flush     = 1'b1;
        step();
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk_out("flush", 1'b0, 64'h3, 1'b0, 5'd12);
`ifdef ALU_EXEC_ACTIVITY_CNT_EN
        chk("flush.cnt_flush", W'(cnt_flush), W'(32'd1));
`endif
        step();
        step();
        chk_out("flush.after", 1'b0, 64'h3, 1'b0, 5'd12);

        // Flush with an accepted op when empty: op is dropped.
        offer(ALU_ADD, 64'h20, 64'h22, 5'd14);
        flush = 1'b1;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk_out("flush.empty", 1'b0, 64'h3, 1'b0, 5'd12);

        // Reset mid-stall: valid clears asynchronously.
        offer(ALU_SUB, 64'h9, 64'h4, 5'd15);
        step();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk_out("rst.load", 1'b1, 64'h5, 1'b0, 5'd15);
        #2;
        rst_n = 1'b0;
        #1;
        chk_out("rst.async", 1'b0, 64'h0, 1'b0, 5'd0);
        step();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        step();
        chk("rst.in_ready", W'(in_ready), W'(1'b1));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
